// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Imported by the byte packer and the loader top.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    RX_LEN,
    RX_WORD,
    WRITE,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction memory write port of the loader.
// master = stream source / memory side, slave = loader.
interface imem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wd
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wd
  );

endinterface

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer with a wrapping lane counter.
// o_word already includes the byte accepted this cycle.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [LANE_W-1:0] r_lane;
  logic [31:0]       r_word;
  logic [31:0]       w_word;
  logic              w_last_lane;

  assign w_last_lane =
    (r_lane == LANE_W'(BYTES_PER_WORD - 1));

  always_comb begin
    w_word = r_word;
    if (i_accept) begin
      unique case (r_lane)
        2'd0: w_word[7:0]   = i_byte;
        2'd1: w_word[15:8]  = i_byte;
        2'd2: w_word[23:16] = i_byte;
        2'd3: w_word[31:24] = i_byte;
        default: w_word = r_word;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_lane <= r_lane + LANE_W'(1);
      r_word <= w_word;
    end
  end

  assign o_word      = w_word;
  assign o_word_full = i_accept && w_last_lane;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + words in, sequential imem writes out.
// Holds the core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus,
  output logic         core_rst,
  output logic         done,
  output logic         error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t r_state;
  state_t w_state_nx;

  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_n;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wd;
  logic             r_core_rst;
  logic             r_done;
  logic             r_error;

  logic        w_ready;
  logic        w_accept;
  logic        w_full;
  logic [31:0] w_word;
  logic        w_last;
  logic [31:0] w_addr;

  assign w_ready =
    (r_state == RX_LEN) || (r_state == RX_WORD);
  assign w_accept = bus.in_valid && w_ready;

  byte_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_accept    (w_accept),
    .i_byte      (bus.in_data),
    .o_word      (w_word),
    .o_word_full (w_full)
  );

  assign w_last = ((32'(r_idx) + 32'd1) == r_n);
  assign w_addr = BASE_ADDR + (32'(r_idx) << 2);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      RX_LEN: begin
        if (w_full) begin
          if (w_word > 32'(MAX_WORDS))
            w_state_nx = ERR;
          else if (w_word == 32'd0)
            w_state_nx = DONE;
          else
            w_state_nx = RX_WORD;
        end
      end
      RX_WORD: begin
        if (w_full) w_state_nx = WRITE;
      end
      WRITE: begin
        w_state_nx = w_last ? DONE : RX_WORD;
      end
      DONE:    w_state_nx = DONE;
      ERR:     w_state_nx = ERR;
      default: w_state_nx = RX_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RX_LEN;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx      <= '0;
      r_n        <= '0;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wd       <= '0;
      r_core_rst <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if ((r_state == RX_LEN) && w_full)
        r_n <= w_word;
      if ((r_state == RX_WORD) && w_full) begin
        r_wd   <= w_word;
        r_addr <= w_addr;
      end
      if (r_state == WRITE)
        r_idx <= r_idx + IDX_W'(1);
      r_we       <= (w_state_nx == WRITE);
      r_done     <= (w_state_nx == DONE);
      r_core_rst <= (w_state_nx == DONE);
      r_error    <= (w_state_nx == ERR);
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.imem_we   = r_we;
  assign bus.imem_addr = r_addr;
  assign bus.imem_wd   = r_wd;
  assign core_rst      = r_core_rst;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: three instances cover the default,
// a small MAX_WORDS and a non-zero BASE_ADDR configuration.
module tb_imem_loader;

  localparam logic [31:0] W0 = 32'h0050_0513;
  localparam logic [31:0] W1 = 32'h00a0_0593;
  localparam logic [31:0] W2 = 32'h00b5_0633;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if b0 ();
  imem_loader_if b1 ();
  imem_loader_if b2 ();

  logic cr0, dn0, er0;
  logic cr1, dn1, er1;
  logic cr2, dn2, er2;

  imem_loader u_dut0 (
    .clk(clk), .rst(rst), .bus(b0),
    .core_rst(cr0), .done(dn0), .error(er0)
  );

  imem_loader #(.MAX_WORDS(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .core_rst(cr1), .done(dn1), .error(er1)
  );

  imem_loader #(.BASE_ADDR(32'h100)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2),
    .core_rst(cr2), .done(dn2), .error(er2)
  );

  int         sel = 0;
  logic       tv = 1'b0;
  logic [7:0] td = 8'h00;

  assign b0.in_valid = tv && (sel == 0);
  assign b1.in_valid = tv && (sel == 1);
  assign b2.in_valid = tv && (sel == 2);
  assign b0.in_data  = td;
  assign b1.in_data  = td;
  assign b2.in_data  = td;

  logic        m_rdy, m_we, m_cr, m_dn, m_er;
  logic [31:0] m_addr, m_wd;

  always_comb begin
    case (sel)
      1: begin
        m_rdy = b1.in_ready; m_we = b1.imem_we;
        m_addr = b1.imem_addr; m_wd = b1.imem_wd;
        m_cr = cr1; m_dn = dn1; m_er = er1;
      end
      2: begin
        m_rdy = b2.in_ready; m_we = b2.imem_we;
        m_addr = b2.imem_addr; m_wd = b2.imem_wd;
        m_cr = cr2; m_dn = dn2; m_er = er2;
      end
      default: begin
        m_rdy = b0.in_ready; m_we = b0.imem_we;
        m_addr = b0.imem_addr; m_wd = b0.imem_wd;
        m_cr = cr0; m_dn = dn0; m_er = er0;
      end
    endcase
  end

  logic [31:0] q_addr[$];
  logic [31:0] q_wd[$];
  int          n_dbl = 0;
  logic        r_pw = 1'b0;

  always @(negedge clk) begin
    if (rst && m_we) begin
      q_addr.push_back(m_addr);
      q_wd.push_back(m_wd);
    end
    if (m_we && r_pw) n_dbl++;
    r_pw = m_we;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic do_reset(input int s);
    @(negedge clk);
    tv  = 1'b0;
    rst = 1'b0;
    sel = s;
    repeat (2) @(negedge clk);
    q_addr.delete();
    q_wd.delete();
    n_dbl = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    tv = 1'b0;
    repeat (gap) @(negedge clk);
    td = b;
    tv = 1'b1;
    t = 0;
    while (!m_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!m_rdy) begin
      n_cmp++; n_err++;
      $display("FAIL send_byte timeout: in_ready=%b want 1", m_rdy);
    end
    @(negedge clk);
    tv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && !m_dn; i++) @(negedge clk);
    n_cmp++;
    if (m_dn !== 1'b1) begin
      n_err++;
      $display("FAIL wait_done: done=%b want 1", m_dn);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    td  = 8'hff;
    tv  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_rdy, m_we, m_cr, m_dn, m_er} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctl: rdy/we/cr/dn/er=%b want 10000",
               {m_rdy, m_we, m_cr, m_dn, m_er});
    end
    n_cmp++;
    if (m_addr !== 32'h0 || m_wd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus: addr=%h wd=%h want 0 0", m_addr, m_wd);
    end
    n_cmp++;
    if (b2.imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL reset_base: addr=%h want 00000100", b2.imem_addr);
    end
    tv  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset(0);
    send_word(32'd2, 0);
    send_word(W0, 0);
    n_cmp++;
    if (m_we !== 1'b1 || m_addr !== 32'h0 || m_wd !== W0) begin
      n_err++;
      $display("FAIL basic_w0: we=%b addr=%h wd=%h want 1 0 %h",
               m_we, m_addr, m_wd, W0);
    end
    send_word(W1, 0);
    n_cmp++;
    if (m_we !== 1'b1 || m_addr !== 32'h4 || m_dn !== 1'b0) begin
      n_err++;
      $display("FAIL basic_w1: we=%b addr=%h done=%b want 1 4 0",
               m_we, m_addr, m_dn);
    end
    @(negedge clk);
    n_cmp++;
    if ({m_we, m_dn, m_cr, m_rdy} !== 4'b0110) begin
      n_err++;
      $display("FAIL basic_done: we/dn/cr/rdy=%b want 0110",
               {m_we, m_dn, m_cr, m_rdy});
    end
    n_cmp++;
    if (q_wd.size() != 2 || q_wd[0] !== W0 || q_wd[1] !== W1) begin
      n_err++;
      $display("FAIL basic_log: writes=%0d want 2 %h %h",
               q_wd.size(), W0, W1);
    end
  endtask

  task automatic test_zero();
    do_reset(0);
    send_word(32'd0, 0);
    n_cmp++;
    if ({m_we, m_dn, m_cr, m_rdy} !== 4'b0110) begin
      n_err++;
      $display("FAIL zero_done: we/dn/cr/rdy=%b want 0110",
               {m_we, m_dn, m_cr, m_rdy});
    end
    td = 8'h55;
    tv = 1'b1;
    repeat (5) @(negedge clk);
    tv = 1'b0;
    n_cmp++;
    if (q_wd.size() != 0 || m_dn !== 1'b1 || m_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL zero_hold: writes=%0d done=%b rdy=%b want 0 1 0",
               q_wd.size(), m_dn, m_rdy);
    end
  endtask

  task automatic test_error();
    int acc;
    do_reset(1);
    send_word(32'd5, 0);
    n_cmp++;
    if ({m_er, m_cr, m_rdy, m_dn} !== 4'b1000) begin
      n_err++;
      $display("FAIL err_flag: er/cr/rdy/dn=%b want 1000",
               {m_er, m_cr, m_rdy, m_dn});
    end
    acc = 0;
    td = 8'h13;
    tv = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_rdy) acc++;
    end
    tv = 1'b0;
    n_cmp++;
    if (acc != 0 || q_wd.size() != 0 || m_er !== 1'b1 ||
        m_cr !== 1'b0) begin
      n_err++;
      $display("FAIL err_hold: acc=%0d writes=%0d er=%b cr=%b want 0 0 1 0",
               acc, q_wd.size(), m_er, m_cr);
    end
  endtask

  task automatic test_max_words();
    do_reset(1);
    send_word(32'd4, 0);
    n_cmp++;
    if (m_er !== 1'b0 || m_rdy !== 1'b1) begin
      n_err++;
      $display("FAIL max_hdr: er=%b rdy=%b want 0 1", m_er, m_rdy);
    end
    send_word(W0, 0);
    send_word(W1, 0);
    send_word(W2, 0);
    send_word(32'hdeadbeef, 0);
    wait_done();
    n_cmp++;
    if (q_addr.size() != 4 || q_addr[3] !== 32'hc ||
        q_wd[3] !== 32'hdeadbeef) begin
      n_err++;
      $display("FAIL max_log: writes=%0d want 4 last @0c deadbeef",
               q_addr.size());
    end
  endtask

  task automatic test_gaps();
    int gaps[12] = '{3, 0, 7, 1, 5, 2, 0, 6, 4, 1, 7, 2};
    logic [31:0] ws[3] = '{W0, W1, W2};
    do_reset(0);
    send_word(32'd3, 0);
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 4; k++)
        send_byte(ws[w][8*k +: 8], gaps[4*w + k]);
    wait_done();
    n_cmp++;
    if (q_addr.size() != 3 ||
        q_addr[0] !== 32'h0 || q_addr[1] !== 32'h4 ||
        q_addr[2] !== 32'h8) begin
      n_err++;
      $display("FAIL gaps_addr: writes=%0d want 3 at 0 4 8",
               q_addr.size());
    end
    n_cmp++;
    if (q_wd.size() != 3 || q_wd[0] !== W0 ||
        q_wd[1] !== W1 || q_wd[2] !== W2) begin
      n_err++;
      $display("FAIL gaps_data: writes=%0d want %h %h %h",
               q_wd.size(), W0, W1, W2);
    end
  endtask

  task automatic test_reset_midload();
    do_reset(0);
    send_word(32'd3, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_word(32'd1, 0);
    send_word(32'hdeadbeef, 0);
    n_cmp++;
    if (m_we !== 1'b1 || m_addr !== 32'h0 ||
        m_wd !== 32'hdeadbeef) begin
      n_err++;
      $display("FAIL rst_mid_wr: we=%b addr=%h wd=%h want 1 0 deadbeef",
               m_we, m_addr, m_wd);
    end
    @(negedge clk);
    n_cmp++;
    if (m_dn !== 1'b1 || q_wd.size() != 1) begin
      n_err++;
      $display("FAIL rst_mid_done: done=%b writes=%0d want 1 1",
               m_dn, q_wd.size());
    end
  endtask

  task automatic test_base_addr();
    do_reset(2);
    send_word(32'd3, 0);
    send_word(W0, 0);
    send_word(W1, 0);
    send_word(W2, 0);
    wait_done();
    n_cmp++;
    if (q_addr.size() != 3 || q_addr[0] !== 32'h100 ||
        q_addr[1] !== 32'h104 || q_addr[2] !== 32'h108) begin
      n_err++;
      $display("FAIL base_addr: writes=%0d want 3 at 100 104 108",
               q_addr.size());
    end
    n_cmp++;
    if (n_dbl != 0 || q_wd.size() != 3 || q_wd[2] !== W2) begin
      n_err++;
      $display("FAIL base_pulse: long_we=%0d writes=%0d want 0 3",
               n_dbl, q_wd.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_error();
    test_max_words();
    test_gaps();
    test_reset_midload();
    test_base_addr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the write side of the core's instruction memory, whose only other port is a read port driven by the PC. It accepts a little-endian byte stream (length header, then instruction words) over a valid/ready interface and assembles 32-bit words. It writes those words sequentially into the instruction memory write port and holds the core in reset until the image is complete.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first instruction word written.
- `MAX_WORDS`, default 1024: instruction memory capacity in words; larger images are rejected.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte-stream source has a byte.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write enable, one-cycle pulse per word.
- `imem_addr`  out  32  word-aligned byte address for the write.
- `imem_wd`  out  32  instruction word to write.
- `core_rst`  out  1  active-low reset to the core, driven low until load completes.
- `done`  out  1  image fully written; sticky.
- `error`  out  1  header length exceeded `MAX_WORDS`; sticky.

## Operation
- A byte is accepted only on a cycle with `in_valid && in_ready`. No other cycle changes byte state.
- Bytes are packed little-endian: the k-th accepted byte of a group (k = 0..3) lands in bits [8k+7:8k]. A 2-bit lane counter wraps 3→0.
- States:
  - RX_LEN: collect 4 bytes into N.
    - On the 4th byte, go to ERR if N > MAX_WORDS, DONE if N == 0, else RX_WORD.
  - RX_WORD: collect 4 bytes into the word register; on the 4th byte go to WRITE.
  - WRITE: `imem_we`=1 for exactly one cycle with `imem_addr` = BASE_ADDR + 4·idx and `imem_wd` = the assembled word. Then idx increments. If idx+1 == N go to DONE, else RX_WORD.
  - DONE: terminal; `done`=1, `core_rst`=1.
  - ERR: terminal; `error`=1, `core_rst` stays 0.
- `in_ready` = 1 only in RX_LEN and RX_WORD. It is 0 in WRITE, DONE and ERR, so bytes after the image or after an error are not consumed.
- idx is clog2(MAX_WORDS+1) bits wide; the address adds idx·4 to BASE_ADDR modulo 2^32.
- Leaving DONE or ERR requires `rst`. There is no soft restart.

## Timing
- Reset values (asynchronous, while `rst`=0):
  - State RX_LEN, lane counter 0, idx 0, N 0.
  - `in_ready`=1, `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wd`=0.
  - `core_rst`=0, `done`=0, `error`=0.
  - Handshakes during reset are ignored.
- `in_ready` is decoded from registered state. All other outputs are registered.
- Write latency: `imem_we` is high in the cycle after the 4th byte's handshake cycle.
- Peak throughput: 4 bytes per 5 cycles (one WRITE bubble per word).
- `done` and `core_rst` rise in the cycle after the last WRITE cycle. For N == 0 they rise in the cycle after the 4th length byte.
- `error` rises in the cycle after the 4th length byte.
- `in_valid` gaps of any length are allowed mid-word. A partial word is held indefinitely.
- Reset mid-load discards the partial word and the count. Words already written are not cleared, and loading restarts at the header.

## Structure
- Shared package holds:
  - the state enum (RX_LEN, RX_WORD, WRITE, DONE, ERR);
  - `BYTES_PER_WORD` = 4;
  - the lane-counter width constant.
- One sub-module is natural: `byte_word_packer`, containing the lane counter, the 32-bit shift/insert register and a `word_full` strobe. It is reused for both the length header and instruction words.

## Test plan
- Header 02 00 00 00, then bytes 13 05 50 00, 93 05 a0 00 → `imem_we` pulses at addresses 0x0 (wd 0x00500513) and 0x4 (wd 0x00a00593); `done`=1 and `core_rst`=1 one cycle after the second write.
- Header 00 00 00 00 → no `imem_we`; `done`=1 one cycle after the 4th byte; `in_ready`=0 thereafter.
- MAX_WORDS=4, header 05 00 00 00 → `error`=1, `core_rst` stays 0, `in_ready`=0, no writes for 100 further `in_valid` cycles.
- Random `in_valid` gaps of 0–7 cycles between bytes of a 3-word image → identical writes and addresses as the gap-free run.
- Assert `rst`=0 after 2 bytes of word 1 of a 3-word image, then reload a fresh 1-word image (deadbeef) → a single write of 0xdeadbeef at BASE_ADDR; `done`=1.
- BASE_ADDR=0x100, 3-word image → writes at 0x100, 0x104 and 0x108, with `imem_we` high for exactly one cycle each.
